// File: rtl/ahb_bus_matrix_arbiter_rr_if.sv
// Bus bundle between the input-stage decoders/output-stage mux and the
// round-robin arbiter of one AHB bus-matrix output port.
interface ahb_bus_matrix_arbiter_rr_if #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
);
  logic [NUM_PORTS-1:0]   req_in;
  logic [2*NUM_PORTS-1:0] trans_in;
  logic [NUM_PORTS-1:0]   mastlock_in;
  logic                   HREADYM;
  logic [PORT_W-1:0]      addr_in_port;
  logic                   no_port;
  logic [PORT_W-1:0]      data_in_port;
  logic                   data_valid;
  logic [NUM_PORTS-1:0]   active_op;

  modport master (
    output req_in, trans_in, mastlock_in, HREADYM,
    input  addr_in_port, no_port, data_in_port, data_valid, active_op
  );

  modport slave (
    input  req_in, trans_in, mastlock_in, HREADYM,
    output addr_in_port, no_port, data_in_port, data_valid, active_op
  );
endinterface

// File: rtl/ahb_bus_matrix_arbiter_rr.sv
// Round-robin owner selection for one AHB bus-matrix output port; holds the
// grant through bursts (SEQ/BUSY) and locked sequences, tracks the data phase.
module ahb_bus_matrix_arbiter_rr #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
) (
  input logic                         HCLK,
  input logic                         HRESET,
  ahb_bus_matrix_arbiter_rr_if.slave  bus
);

  logic [PORT_W-1:0]    owner_q;
  logic                 no_port_q;
  logic [PORT_W-1:0]    data_in_port_q;
  logic                 data_valid_q;

  logic [PORT_W-1:0]    grant_d;
  logic                 none_d;
  logic [1:0]           owner_trans_s;
  logic                 owner_req_s;
  logic                 owner_lock_s;
  logic                 hold_s;
  logic [PORT_W-1:0]    scan_idx_s;
  logic                 scan_hit_s;
  logic [NUM_PORTS-1:0] active_s;

  // Port index base+step with the wrap from NUM_PORTS-1 back to 0.
  function automatic logic [PORT_W-1:0] wrap_idx(input logic [PORT_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    return (s >= NUM_PORTS) ? PORT_W'(s - NUM_PORTS) : PORT_W'(s);
  endfunction

  // Current owner's request, HTRANS and lock, muxed by owner index.
  always_comb begin
    owner_trans_s = 2'b00;
    owner_req_s   = 1'b0;
    owner_lock_s  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      owner_trans_s = owner_trans_s | (bus.trans_in[2*i +: 2] & {2{owner_q == PORT_W'(i)}});
      owner_req_s   = owner_req_s   | (bus.req_in[i]      & (owner_q == PORT_W'(i)));
      owner_lock_s  = owner_lock_s  | (bus.mastlock_in[i] & (owner_q == PORT_W'(i)));
    end
  end

  assign hold_s = ~no_port_q & owner_req_s &
                  ((owner_trans_s == 2'b11) | (owner_trans_s == 2'b01) | owner_lock_s);

  // Round-robin scan: walked farthest-first so the nearest requester after owner wins.
  always_comb begin
    scan_idx_s = owner_q;
    scan_hit_s = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      scan_idx_s = bus.req_in[wrap_idx(owner_q, k)] ? wrap_idx(owner_q, k) : scan_idx_s;
      scan_hit_s = scan_hit_s | bus.req_in[wrap_idx(owner_q, k)];
    end
  end

  // Address-phase grant; frozen while the output port inserts wait states.
  always_comb begin
    grant_d = owner_q;
    none_d  = no_port_q;
    if (bus.HREADYM) begin
      if (hold_s) begin
        grant_d = owner_q;
        none_d  = 1'b0;
      end else if (scan_hit_s) begin
        grant_d = scan_idx_s;
        none_d  = 1'b0;
      end else begin
        grant_d = owner_q;
        none_d  = 1'b1;
      end
    end else begin
      grant_d = owner_q;
      none_d  = no_port_q;
    end
  end

  // One-hot active feedback to each decoder.
  always_comb begin
    active_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      active_s[i] = (grant_d == PORT_W'(i)) & ~none_d;
    end
  end

  // Owner and data-phase state advance only on HREADYM-qualified edges.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q        <= '0;
      no_port_q      <= 1'b1;
      data_in_port_q <= '0;
      data_valid_q   <= 1'b0;
    end else if (bus.HREADYM) begin
      owner_q        <= grant_d;
      no_port_q      <= none_d;
      data_in_port_q <= grant_d;
      data_valid_q   <= ~none_d;
    end else begin
      owner_q        <= owner_q;
      no_port_q      <= no_port_q;
      data_in_port_q <= data_in_port_q;
      data_valid_q   <= data_valid_q;
    end
  end

  assign bus.addr_in_port = grant_d;
  assign bus.no_port      = none_d;
  assign bus.data_in_port = data_in_port_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.active_op    = active_s;

endmodule

// File: tb/tb_ahb_bus_matrix_arbiter_rr.sv
// Directed bench for the round-robin output-port arbiter (3 ports).
module tb_ahb_bus_matrix_arbiter_rr;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ahb_bus_matrix_arbiter_rr_if #(.NUM_PORTS(3), .PORT_W(2)) bus_if ();

  ahb_bus_matrix_arbiter_rr #(.NUM_PORTS(3), .PORT_W(2)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_trans(input int p, input logic [1:0] t);
    bus_if.trans_in[2*p +: 2] = t;
  endtask

  initial begin
    int fair_exp [6];
    logic [1:0] burst_tr [5];
    int burst_exp [5];
    int prev;
    checks = 0;
    errors = 0;
    fair_exp  = '{1, 2, 0, 1, 2, 0};
    burst_tr  = '{NONSEQ, SEQ, BUSY, SEQ, IDLE};
    burst_exp = '{0, 0, 0, 0, 2};

    // Reset with every port requesting
    rst = 1'b1;
    bus_if.req_in      = 3'b111;
    bus_if.trans_in    = {NONSEQ, NONSEQ, NONSEQ};
    bus_if.mastlock_in = 3'b000;
    bus_if.HREADYM     = 1'b1;
    tick();
    tick();
    chk("rst_data_valid", 32'(bus_if.data_valid), 32'd0);
    chk("rst_data_in_port", 32'(bus_if.data_in_port), 32'd0);
    rst = 1'b0;
    bus_if.req_in = 3'b000;
    #1;
    chk("idle_no_port", 32'(bus_if.no_port), 32'd1);
    chk("idle_addr", 32'(bus_if.addr_in_port), 32'd0);
    chk("idle_active", 32'(bus_if.active_op), 32'd0);
    // Freeze exposes the reset no_port_q even with requests present
    bus_if.HREADYM = 1'b0;
    bus_if.req_in  = 3'b111;
    #1;
    chk("frz_no_port", 32'(bus_if.no_port), 32'd1);
    chk("frz_active", 32'(bus_if.active_op), 32'd0);

    // Single requester, zero-cycle grant then data phase
    bus_if.HREADYM = 1'b1;
    bus_if.req_in  = 3'b010;
    #1;
    chk("single_addr", 32'(bus_if.addr_in_port), 32'd1);
    chk("single_no_port", 32'(bus_if.no_port), 32'd0);
    chk("single_active", 32'(bus_if.active_op), 32'b010);
    tick();
    chk("single_dip", 32'(bus_if.data_in_port), 32'd1);
    chk("single_dv", 32'(bus_if.data_valid), 32'd1);
    bus_if.req_in = 3'b000;
    tick();
    chk("release_dv", 32'(bus_if.data_valid), 32'd0);

    // Fairness from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.req_in = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fair_addr%0d", i), 32'(bus_if.addr_in_port), 32'(fair_exp[i]));
      tick();
      chk($sformatf("fair_dip%0d", i), 32'(bus_if.data_in_port), 32'(fair_exp[i]));
    end

    // Move ownership to port 2 so port 0 is next in line
    bus_if.req_in = 3'b100;
    #1;
    chk("pre_burst_addr", 32'(bus_if.addr_in_port), 32'd2);
    tick();

    // Burst hold: port 0 NONSEQ,SEQ,BUSY,SEQ then IDLE while port 2 waits
    bus_if.req_in = 3'b101;
    prev = 2;
    for (int i = 0; i < 5; i++) begin
      set_trans(0, burst_tr[i]);
      #1;
      chk($sformatf("burst_addr%0d", i), 32'(bus_if.addr_in_port), 32'(burst_exp[i]));
      chk($sformatf("burst_dip%0d", i), 32'(bus_if.data_in_port), 32'(prev));
      tick();
      prev = burst_exp[i];
    end
    set_trans(0, NONSEQ);

    // Wait states: port 1 owns, port 2 requests
    bus_if.req_in = 3'b010;
    #1;
    chk("ws_own_addr", 32'(bus_if.addr_in_port), 32'd1);
    tick();
    bus_if.req_in  = 3'b110;
    bus_if.HREADYM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ws_addr%0d", i), 32'(bus_if.addr_in_port), 32'd1);
      chk($sformatf("ws_dip%0d", i), 32'(bus_if.data_in_port), 32'd1);
      chk($sformatf("ws_active%0d", i), 32'(bus_if.active_op), 32'b010);
      tick();
    end
    bus_if.HREADYM = 1'b1;
    #1;
    chk("ws_regrant", 32'(bus_if.addr_in_port), 32'd2);
    tick();
    chk("ws_regrant_dip", 32'(bus_if.data_in_port), 32'd2);

    // Locked port 2: NONSEQ then IDLE held despite port 0, reset mid-sequence
    bus_if.req_in      = 3'b101;
    bus_if.mastlock_in = 3'b100;
    set_trans(2, NONSEQ);
    #1;
    chk("lock_addr0", 32'(bus_if.addr_in_port), 32'd2);
    tick();
    set_trans(2, IDLE);
    #1;
    chk("lock_addr1", 32'(bus_if.addr_in_port), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("lock_rst_dv", 32'(bus_if.data_valid), 32'd0);
    chk("lock_rst_dip", 32'(bus_if.data_in_port), 32'd0);
    bus_if.HREADYM = 1'b0;
    #1;
    chk("lock_rst_no_port", 32'(bus_if.no_port), 32'd1);
    bus_if.HREADYM = 1'b1;
    set_trans(2, NONSEQ);
    #1;
    chk("lock_addr2", 32'(bus_if.addr_in_port), 32'd2);
    chk("lock_no_port2", 32'(bus_if.no_port), 32'd0);
    tick();
    // Lock dropped with IDLE: releasing owner loses to port 0
    bus_if.mastlock_in = 3'b000;
    set_trans(2, IDLE);
    #1;
    chk("unlock_addr", 32'(bus_if.addr_in_port), 32'd0);
    chk("unlock_active", 32'(bus_if.active_op), 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_bus_matrix_arbiter_rr.md
# ahb_bus_matrix_arbiter_rr

Round-robin arbiter for one output stage of the AHB bus matrix. Several input stages, routed through their decoders, may select the same output port (slave interface). This block decides which input port owns the output port's address phase. It tracks the owner into the data phase and holds ownership across bursts and locked sequences. It drives the port-select controls consumed by the output-stage multiplexer and the `active` feedback returned to each decoder.

## Interface
Parameters:
- `NUM_PORTS`, 3: number of input ports competing for this output port (2..8).
- `PORT_W`, 2: width of port index; must satisfy 2^PORT_W >= NUM_PORTS.

Ports:
- `HCLK`  in  1  AHB system clock; single clock domain.
- `HRESET`  in  1  synchronous, active-high reset.
- `req_in`  in  NUM_PORTS  per-port request: decoder select for this output port.
- `trans_in`  in  2*NUM_PORTS  per-port HTRANS; port i occupies [2i+1:2i].
- `mastlock_in`  in  NUM_PORTS  per-port HMASTLOCK.
- `HREADYM`  in  1  HREADY of this output port (transfer completes / bus free).
- `addr_in_port`  out  PORT_W  combinational index of the address-phase owner.
- `no_port`  out  1  combinational; 1 means no port is granted and the output stage drives IDLE.
- `data_in_port`  out  PORT_W  registered index of the data-phase owner.
- `data_valid`  out  1  registered; 1 means a granted transfer is in its data phase.
- `active_op`  out  NUM_PORTS  one-hot; `active_op[i] = (addr_in_port==i) & ~no_port`.

## Operation
- State registers:
  - `owner_q`: last granted port.
  - `no_port_q`: last cycle had no grant.
  - `data_in_port`.
  - `data_valid`.
- Hold condition: ownership is held when all of the following are true:
  - `no_port_q=0`;
  - `req_in[owner_q]=1`;
  - `trans_in[owner_q]` is SEQ (2'b11) or BUSY (2'b01), or `mastlock_in[owner_q]=1`.
- Arbitration, combinational, applied only when HREADYM=1:
  - If the hold condition is true, the result is `owner_q`.
  - Otherwise, scan ports `owner_q+1`, `owner_q+2`, … modulo NUM_PORTS, ending with `owner_q` itself. The first port with `req_in=1` wins.
  - If no port requests, the result is `no_port=1` and `addr_in_port=owner_q`.
- Freeze: when HREADYM=0, `addr_in_port=owner_q` and `no_port=no_port_q`. No re-arbitration occurs and requests are ignored.
- Register update on HCLK rising edge with HREADYM=1:
  - `owner_q <= addr_in_port`;
  - `no_port_q <= no_port`;
  - `data_in_port <= addr_in_port`;
  - `data_valid <= ~no_port`.
- Register update with HREADYM=0: all registers hold.
- A locked owner issuing IDLE with `mastlock_in=1` keeps the grant. The grant is released at the first HREADYM=1 cycle where `mastlock_in[owner]=0` and its trans is not SEQ or BUSY.
- Indices of NUM_PORTS or above never appear. The modulo wrap is explicit, from NUM_PORTS-1 to 0.

## Timing
- Reset (HRESET=1 at an edge) overrides HREADYM. Reset values:
  - `owner_q=0`;
  - `no_port_q=1`;
  - `data_in_port=0`;
  - `data_valid=0`.
- Outputs in the cycle after reset, with no requests: `no_port=1`, `addr_in_port=0`, `active_op=0`.
- Grant latency: zero cycles. A request present with HREADYM=1 is reflected on `addr_in_port`, `no_port` and `active_op` in the same cycle.
- Data-phase latency: one HREADYM-qualified edge. `data_in_port` and `data_valid` follow the address grant at the next edge where HREADYM=1.
- Simultaneous events:
  - A new request arriving in the same cycle the owner releases competes under round-robin order. The releasing owner has the lowest priority.
  - Reset mid-burst aborts ownership. The next cycle shows `no_port=1`, `data_valid=0`.
- A port switch is possible every HREADYM=1 cycle; there is no dead cycle between owners.

## Test plan
- Reset: hold HRESET=1 for 2 cycles with all `req_in=1` -> `no_port_q=1`, `data_valid=0`, `data_in_port=0`; after release with `req_in=0`, `no_port=1` and `active_op=0`.
- Single requester: port 1 issues NONSEQ with HREADYM=1 -> same cycle `addr_in_port=1`, `no_port=0`, `active_op=3'b010`; next edge `data_in_port=1`, `data_valid=1`.
- Fairness: ports 0/1/2 request NONSEQ continuously with HREADYM=1 from reset -> grant sequence 1,2,0,1,2,0; each port gets exactly one cycle in three.
- Burst hold: port 0 issues INCR4 (NONSEQ, SEQ, SEQ, SEQ) while port 2 requests -> `addr_in_port=0` for 4 cycles, then 2 in cycle 5; `data_in_port` lags by one cycle.
- Wait states: port 1 owns, port 2 requests, HREADYM=0 for 3 cycles -> `addr_in_port=1` and `data_in_port` unchanged throughout; first HREADYM=1 cycle grants port 2.
- Lock and reset: port 2 with `mastlock_in=1` issues NONSEQ, IDLE, NONSEQ while port 0 requests -> port 2 is held all three cycles. Asserting HRESET in cycle 2 gives `no_port_q=1` and `data_valid=0` on the next cycle.
